// File: rtl/id_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg
// Shared definitions for the instruction-decode slice: datapath width,
// register-file geometry, the 3-bit ALU opcode set and the RISC-V opcode and
// funct constants that the decoder recognises.
// Optional build macro used by this slice: ID_BYPASS_EN (see id_regfile).
// -----------------------------------------------------------------------------
package id_pkg;

    localparam int DATA_W = 32;
    localparam int REG_N  = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_NOT = 3'd4
    } alu_op_e;

    localparam logic [6:0]  OPC_OP       = 7'b0110011;
    localparam logic [6:0]  OPC_OP_IMM   = 7'b0010011;
    localparam logic [2:0]  F3_ADD_SUB   = 3'b000;
    localparam logic [2:0]  F3_XOR       = 3'b100;
    localparam logic [2:0]  F3_OR        = 3'b110;
    localparam logic [2:0]  F3_AND       = 3'b111;
    localparam logic [6:0]  F7_BASE      = 7'b0000000;
    localparam logic [6:0]  F7_ALT       = 7'b0100000;
    localparam logic [11:0] IMM_ALL_ONES = 12'hFFF;

    // Sign-extend a 12-bit I-type immediate to the datapath width.
    function automatic logic [DATA_W-1:0] sext12(input logic [11:0] imm);
        return {{(DATA_W-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/id_regfile.sv
// -----------------------------------------------------------------------------
// id_regfile
// 32x32 register file plus a pending-write scoreboard for the decode stage.
// x0 always reads zero and ignores writes.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   rs1_addr_i/rs2_addr_i   source register addresses
//   rd_addr_i               destination address checked for a pending write
//   rs1_data_o/rs2_data_o   source operand values
//   rs1_busy_o/rs2_busy_o   source register has an outstanding write
//   rd_busy_o               destination register has an outstanding write
//   wb_we_i/wb_rd_i/wb_data_i  writeback port (also clears the pending bit)
//   issue_i/issue_rd_i      marks issue_rd_i pending when an instruction issues
//
// Build macro ID_BYPASS_EN: a writeback in the same cycle is forwarded to the
// operand reads and hides the pending bit it is about to clear.
// -----------------------------------------------------------------------------
module id_regfile
    import id_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rs1_data_o,
    output logic [DATA_W-1:0] rs2_data_o,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o,
    output logic              rd_busy_o,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              issue_i,
    input  logic [REG_AW-1:0] issue_rd_i
);

    logic [DATA_W-1:0] regs_q [REG_N];
    logic [REG_N-1:0]  pend_q;
    logic [REG_N-1:0]  pend_d;
    logic [REG_N-1:0]  clr_mask;
    logic [REG_N-1:0]  set_mask;
    logic [REG_N-1:0]  pend_eff;

    // Register storage. Entry 0 is never written so it stays at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < REG_N; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we_i && (wb_rd_i != '0)) begin
            regs_q[wb_rd_i] <= wb_data_i;
        end
    end

    // Scoreboard next state: the clear is applied first and the set after it,
    // so an issue and a writeback to the same register leave the bit set.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wb_we_i) begin
            clr_mask = REG_N'(1) << wb_rd_i;
        end
        if (issue_i && (issue_rd_i != '0)) begin
            set_mask = REG_N'(1) << issue_rd_i;
        end
        pend_d = (pend_q & ~clr_mask) | set_mask;
    end

    // Scoreboard register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Operand reads and busy flags. With forwarding enabled the writeback
    // that lands this cycle is visible immediately (write-first).
    always_comb begin
        rs1_data_o = (rs1_addr_i == '0) ? '0 : regs_q[rs1_addr_i];
        rs2_data_o = (rs2_addr_i == '0) ? '0 : regs_q[rs2_addr_i];
        pend_eff   = pend_q;
`ifdef ID_BYPASS_EN
        pend_eff = pend_q & ~clr_mask;
        if (wb_we_i && (wb_rd_i != '0) && (wb_rd_i == rs1_addr_i)) begin
            rs1_data_o = wb_data_i;
        end
        if (wb_we_i && (wb_rd_i != '0) && (wb_rd_i == rs2_addr_i)) begin
            rs2_data_o = wb_data_i;
        end
`endif
        rs1_busy_o = pend_eff[rs1_addr_i];
        rs2_busy_o = pend_eff[rs2_addr_i];
        rd_busy_o  = pend_eff[rd_addr_i];
    end

endmodule

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
// Decode stage: accepts RISC-V words from fetch, decodes a small ALU subset,
// reads operands, tracks hazards and presents one registered operation to
// execute.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   inst_i/inst_valid_i/inst_ready_o   fetch handshake
//   wb_we_i/wb_rd_i/wb_data_i    register-file writeback
//   num1_o/num2_o/op_o/rd_o      ALU operands, opcode, destination
//   valid_o/ready_i              execute handshake
//   illegal_o                    pulse after an undecodable word is accepted
//
// Build macro ID_BYPASS_EN: forwards same-cycle writebacks (in id_regfile).
// -----------------------------------------------------------------------------
module id_stage
    import id_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       inst_i,
    input  logic              inst_valid_i,
    output logic              inst_ready_o,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] num1_o,
    output logic [DATA_W-1:0] num2_o,
    output logic [2:0]        op_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              illegal_o
);

    logic [6:0]        f_opcode;
    logic [2:0]        f_funct3;
    logic [6:0]        f_funct7;
    logic [REG_AW-1:0] f_rd;
    logic [REG_AW-1:0] f_rs1;
    logic [REG_AW-1:0] f_rs2;
    logic [11:0]       f_imm;

    logic              dec_legal;
    logic              dec_is_r;
    logic              dec_is_not;
    alu_op_e           dec_op;
    logic [DATA_W-1:0] dec_num2;

    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              rd_busy;
    logic              hazard;
    logic              accept;

    logic              valid_q,   valid_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] num1_q,    num1_d;
    logic [DATA_W-1:0] num2_q,    num2_d;
    alu_op_e           op_q,      op_d;
    logic [REG_AW-1:0] rd_q,      rd_d;

    assign f_opcode = inst_i[6:0];
    assign f_rd     = inst_i[11:7];
    assign f_funct3 = inst_i[14:12];
    assign f_rs1    = inst_i[19:15];
    assign f_rs2    = inst_i[24:20];
    assign f_funct7 = inst_i[31:25];
    assign f_imm    = inst_i[31:20];

    // Decoder. Anything not matched below stays illegal. XORI is only
    // accepted with an all-ones immediate, where it becomes a bitwise NOT.
    always_comb begin
        dec_legal  = 1'b0;
        dec_is_r   = 1'b0;
        dec_is_not = 1'b0;
        dec_op     = ALU_ADD;
        case (f_opcode)
            OPC_OP: begin
                dec_is_r = 1'b1;
                case (f_funct3)
                    F3_ADD_SUB: begin
                        if (f_funct7 == F7_BASE) begin
                            dec_legal = 1'b1;
                            dec_op    = ALU_ADD;
                        end else if (f_funct7 == F7_ALT) begin
                            dec_legal = 1'b1;
                            dec_op    = ALU_SUB;
                        end
                    end
                    F3_AND: begin
                        dec_legal = (f_funct7 == F7_BASE);
                        dec_op    = ALU_AND;
                    end
                    F3_OR: begin
                        dec_legal = (f_funct7 == F7_BASE);
                        dec_op    = ALU_OR;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                case (f_funct3)
                    F3_ADD_SUB: begin dec_legal = 1'b1; dec_op = ALU_ADD; end
                    F3_AND:     begin dec_legal = 1'b1; dec_op = ALU_AND; end
                    F3_OR:      begin dec_legal = 1'b1; dec_op = ALU_OR;  end
                    F3_XOR: begin
                        dec_legal  = (f_imm == IMM_ALL_ONES);
                        dec_is_not = 1'b1;
                        dec_op     = ALU_NOT;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Second operand: register for R-type, zero for NOT, otherwise the
    // sign-extended immediate.
    always_comb begin
        if (dec_is_r) begin
            dec_num2 = rs2_data;
        end else if (dec_is_not) begin
            dec_num2 = '0;
        end else begin
            dec_num2 = sext12(f_imm);
        end
    end

    id_regfile u_regfile (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rs1_addr_i (f_rs1),
        .rs2_addr_i (f_rs2),
        .rd_addr_i  (f_rd),
        .rs1_data_o (rs1_data),
        .rs2_data_o (rs2_data),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .rd_busy_o  (rd_busy),
        .wb_we_i    (wb_we_i),
        .wb_rd_i    (wb_rd_i),
        .wb_data_i  (wb_data_i),
        .issue_i    (accept && dec_legal),
        .issue_rd_i (f_rd)
    );

    // Illegal words touch no registers, so they never wait on the scoreboard.
    assign hazard       = dec_legal && (rs1_busy || (dec_is_r && rs2_busy) || rd_busy);
    assign inst_ready_o = (!valid_q || ready_i) && !hazard;
    assign accept       = inst_valid_i && inst_ready_o;

    // Output-stage next state. A legal accept loads a new operation; an
    // illegal accept empties the stage and raises the one-cycle flag;
    // otherwise the operation leaves once execute takes it.
    always_comb begin
        valid_d   = valid_q;
        illegal_d = 1'b0;
        num1_d    = num1_q;
        num2_d    = num2_q;
        op_d      = op_q;
        rd_d      = rd_q;
        if (accept && dec_legal) begin
            valid_d = 1'b1;
            num1_d  = rs1_data;
            num2_d  = dec_num2;
            op_d    = dec_op;
            rd_d    = f_rd;
        end else if (accept) begin
            valid_d   = 1'b0;
            illegal_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Output-stage registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            num1_q    <= '0;
            num2_q    <= '0;
            op_q      <= ALU_ADD;
            rd_q      <= '0;
        end else begin
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            num1_q    <= num1_d;
            num2_q    <= num2_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
        end
    end

    assign valid_o   = valid_q;
    assign illegal_o = illegal_q;
    assign num1_o    = num1_q;
    assign num2_o    = num2_q;
    assign op_o      = op_q;
    assign rd_o      = rd_q;

endmodule
